// File: rtl/param_single_port_ram.sv
// Single-port synchronous RAM with a power-up/on-demand clear sequencer.
// Latency: every accepted access completes 1 + OUT_REG cycles after its request edge.
// Backpressure: none toward the requester; requests are dropped while busy is high.
//
// Ports:
//   clk      sole clock, rising edge
//   rst      synchronous reset, active-high; starts a full clear
//   en       access request, sampled each rising edge
//   we       1 = write, 0 = read (only meaningful with en)
//   addr     word address
//   data     write data
//   clr      request a full-memory clear to INIT_VAL (honoured only when ready)
//   q        read/port data, holds its last value between completions
//   q_valid  one-cycle pulse marking new data on q
//   busy     high while the clear sequencer owns the array
module param_single_port_ram #(
    parameter int unsigned        DATA_W   = 8,
    parameter int unsigned        ADDR_W   = 6,
    parameter int unsigned        RDW_MODE = 0,   // 0 = read-first, 1 = write-first
    parameter int unsigned        OUT_REG  = 0,   // 1 = extra output pipeline stage
    parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic              clr,
    output logic [DATA_W-1:0] q,
    output logic              q_valid,
    output logic              busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Clear sequencer FSM
    // ------------------------------------------------------------------
    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. The counter naturally wraps back to zero after the
    // last word, so it is already correct for the next clear request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + ADDR_W'(1);
                // All-ones counter means the last word is written this edge.
                if (&cnt_q) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                // A same-cycle access still completes; the clear starts
                // owning the array from the next edge on.
                if (clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: busy comes straight from the state register, and the
    // array write port is multiplexed between the sequencer and the user.
    logic              acc;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;

    always_comb begin
        busy   = (state_q == ST_CLEAR);
        acc    = 1'b0;
        mem_we = 1'b0;
        mem_wa = addr;
        mem_wd = data;
        unique case (state_q)
            ST_CLEAR: begin
                mem_we = 1'b1;
                mem_wa = cnt_q;
                mem_wd = INIT_VAL;
            end
            ST_READY: begin
                acc    = en;
                mem_we = en & we;
            end
            default: begin
                acc    = 1'b0;
                mem_we = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage array (no reset: contents are rebuilt by the clear sequencer)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Writes are suppressed on a reset edge; the following clear rewrites
    // every word anyway, this only keeps reset edges side-effect free.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    // ------------------------------------------------------------------
    // Read-during-write selection
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rd_dat;

    generate
        if (RDW_MODE != 0) begin : g_write_first
            // A write returns the new data on q.
            always_comb begin
                rd_dat = we ? data : mem_q[addr];
            end
        end else begin : g_read_first
            // The array read sees the pre-edge contents, so a write returns
            // the word it is about to overwrite.
            always_comb begin
                rd_dat = mem_q[addr];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 1: registered array output
    // ------------------------------------------------------------------
    logic              s1_vld_q;
    logic              s1_vld_d;
    logic [DATA_W-1:0] s1_dat_q;
    logic [DATA_W-1:0] s1_dat_d;

    // Data only advances on an accepted access so q holds between accesses.
    always_comb begin
        s1_vld_d = acc;
        s1_dat_d = acc ? rd_dat : s1_dat_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s1_dat_q <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_dat_q <= s1_dat_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional stage 2. It does not look at the FSM, so a result already in
    // flight when a clear begins still completes; only rst drops it.
    // ------------------------------------------------------------------
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              s2_vld_q;
            logic              s2_vld_d;
            logic [DATA_W-1:0] s2_dat_q;
            logic [DATA_W-1:0] s2_dat_d;

            always_comb begin
                s2_vld_d = s1_vld_q;
                s2_dat_d = s1_vld_q ? s1_dat_q : s2_dat_q;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_vld_q <= 1'b0;
                    s2_dat_q <= '0;
                end else begin
                    s2_vld_q <= s2_vld_d;
                    s2_dat_q <= s2_dat_d;
                end
            end

            assign q       = s2_dat_q;
            assign q_valid = s2_vld_q;
        end else begin : g_no_out_reg
            assign q       = s1_dat_q;
            assign q_valid = s1_vld_q;
        end
    endgenerate

endmodule

// File: tb/tb_param_single_port_ram.sv
// Directed bench for param_single_port_ram.
// Three instances share one stimulus stream:
//   d0: read-first, no output reg, INIT 00   d1: write-first, no output reg, INIT 00
//   d2: write-first, output reg, INIT FF
module tb_param_single_port_ram;

    logic       clk;
    logic       rst;
    logic       en;
    logic       we;
    logic [5:0] addr;
    logic [7:0] data;
    logic       clr;

    logic [7:0] q_w    [3];
    logic       qv_w   [3];
    logic       busy_w [3];

    int n_chk  = 0;
    int n_pass = 0;

    param_single_port_ram #(.DATA_W(8), .ADDR_W(6), .RDW_MODE(0), .OUT_REG(0), .INIT_VAL(8'h00)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .data(data), .clr(clr),
        .q(q_w[0]), .q_valid(qv_w[0]), .busy(busy_w[0])
    );

    param_single_port_ram #(.DATA_W(8), .ADDR_W(6), .RDW_MODE(1), .OUT_REG(0), .INIT_VAL(8'h00)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .data(data), .clr(clr),
        .q(q_w[1]), .q_valid(qv_w[1]), .busy(busy_w[1])
    );

    param_single_port_ram #(.DATA_W(8), .ADDR_W(6), .RDW_MODE(1), .OUT_REG(1), .INIT_VAL(8'hFF)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .data(data), .clr(clr),
        .q(q_w[2]), .q_valid(qv_w[2]), .busy(busy_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, 64-cycle busy window, first read of the top address.
    task automatic test_reset();
        int bc [3];
        rst = 1'b1; en = 1'b0; we = 1'b0; clr = 1'b0; addr = '0; data = '0;
        tick();
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            n_chk++;
            if (busy_w[d] !== 1'b1 || q_w[d] !== 8'h00 || qv_w[d] !== 1'b0)
                $display("FAIL reset_state d%0d: busy=%b q=%h v=%b, want busy=1 q=00 v=0",
                         d, busy_w[d], q_w[d], qv_w[d]);
            else n_pass++;
            bc[d] = 0;
        end
        for (int i = 0; i < 70; i++) begin
            for (int d = 0; d < 3; d++) if (busy_w[d] === 1'b1) bc[d]++;
            tick();
        end
        for (int d = 0; d < 3; d++) begin
            n_chk++;
            if (bc[d] != 64 || busy_w[d] !== 1'b0)
                $display("FAIL reset_busy_len d%0d: busy cycles=%0d now=%b, want 64 now=0",
                         d, bc[d], busy_w[d]);
            else n_pass++;
        end
        en = 1'b1; we = 1'b0; addr = 6'd63;
        tick();
        en = 1'b0;
        n_chk++;
        if (q_w[0] !== 8'h00 || qv_w[0] !== 1'b1 || q_w[1] !== 8'h00 || qv_w[1] !== 1'b1 || qv_w[2] !== 1'b0)
            $display("FAIL read63_l1: d0 q=%h v=%b d1 q=%h v=%b d2 v=%b, want 00/1 00/1 v=0",
                     q_w[0], qv_w[0], q_w[1], qv_w[1], qv_w[2]);
        else n_pass++;
        tick();
        n_chk++;
        if (q_w[2] !== 8'hFF || qv_w[2] !== 1'b1 || qv_w[0] !== 1'b0 || qv_w[1] !== 1'b0)
            $display("FAIL read63_l2: d2 q=%h v=%b d0 v=%b d1 v=%b, want FF/1 v=0 v=0",
                     q_w[2], qv_w[2], qv_w[0], qv_w[1]);
        else n_pass++;
    endtask

    // Back-to-back writes of 01..05 then back-to-back reads of addr 0..4.
    task automatic test_back_to_back();
        logic [7:0] eq [3];
        logic       ev [3];
        for (int i = 0; i < 5; i++) begin
            en = 1'b1; we = 1'b1; addr = 6'(i); data = 8'(i + 1);
            tick();
            eq[0] = 8'h00;    ev[0] = 1'b1;
            eq[1] = 8'(i + 1); ev[1] = 1'b1;
            eq[2] = (i >= 1) ? 8'(i) : 8'hFF; ev[2] = (i >= 1);
            for (int d = 0; d < 3; d++) begin
                n_chk++;
                if (q_w[d] !== eq[d] || qv_w[d] !== ev[d])
                    $display("FAIL write_seq d%0d i%0d: q=%h v=%b, want q=%h v=%b",
                             d, i, q_w[d], qv_w[d], eq[d], ev[d]);
                else n_pass++;
            end
        end
        en = 1'b0; we = 1'b0;
        tick();
        n_chk++;
        if (q_w[0] !== 8'h00 || qv_w[0] !== 1'b0 || q_w[1] !== 8'h05 || qv_w[1] !== 1'b0 ||
            q_w[2] !== 8'h05 || qv_w[2] !== 1'b1)
            $display("FAIL write_tail: d0 %h/%b d1 %h/%b d2 %h/%b, want 00/0 05/0 05/1",
                     q_w[0], qv_w[0], q_w[1], qv_w[1], q_w[2], qv_w[2]);
        else n_pass++;
        for (int k = 0; k < 7; k++) begin
            en = (k < 5); we = 1'b0; addr = 6'(k % 5);
            tick();
            eq[0] = (k < 5) ? 8'(k + 1) : 8'h05; ev[0] = (k < 5);
            eq[1] = eq[0];                       ev[1] = ev[0];
            eq[2] = (k == 0) ? 8'h05 : ((k < 5) ? 8'(k) : 8'h05);
            ev[2] = (k >= 1 && k <= 5);
            for (int d = 0; d < 3; d++) begin
                n_chk++;
                if (q_w[d] !== eq[d] || qv_w[d] !== ev[d])
                    $display("FAIL read_seq d%0d k%0d: q=%h v=%b, want q=%h v=%b",
                             d, k, q_w[d], qv_w[d], eq[d], ev[d]);
                else n_pass++;
            end
        end
        en = 1'b0;
    endtask

    // Same-address read-during-write behaviour.
    task automatic test_rdw();
        en = 1'b1; we = 1'b1; addr = 6'd5; data = 8'hAA;
        tick();
        en = 1'b0;
        tick();
        en = 1'b1; we = 1'b1; addr = 6'd5; data = 8'h55;
        tick();
        n_chk++;
        if (q_w[0] !== 8'hAA || qv_w[0] !== 1'b1 || q_w[1] !== 8'h55 || qv_w[1] !== 1'b1 ||
            q_w[2] !== 8'hAA || qv_w[2] !== 1'b0)
            $display("FAIL rdw_write: d0 %h/%b d1 %h/%b d2 %h/%b, want AA/1 55/1 AA/0",
                     q_w[0], qv_w[0], q_w[1], qv_w[1], q_w[2], qv_w[2]);
        else n_pass++;
        we = 1'b0;
        tick();
        en = 1'b0;
        n_chk++;
        if (q_w[0] !== 8'h55 || qv_w[0] !== 1'b1 || q_w[1] !== 8'h55 || qv_w[1] !== 1'b1 ||
            q_w[2] !== 8'h55 || qv_w[2] !== 1'b1)
            $display("FAIL rdw_read: d0 %h/%b d1 %h/%b d2 %h/%b, want 55/1 55/1 55/1",
                     q_w[0], qv_w[0], q_w[1], qv_w[1], q_w[2], qv_w[2]);
        else n_pass++;
        tick();
        n_chk++;
        if (q_w[0] !== 8'h55 || qv_w[0] !== 1'b0 || q_w[1] !== 8'h55 || qv_w[1] !== 1'b0 ||
            q_w[2] !== 8'h55 || qv_w[2] !== 1'b1)
            $display("FAIL rdw_hold: d0 %h/%b d1 %h/%b d2 %h/%b, want 55/0 55/0 55/1",
                     q_w[0], qv_w[0], q_w[1], qv_w[1], q_w[2], qv_w[2]);
        else n_pass++;
        tick();
        n_chk++;
        if (q_w[2] !== 8'h55 || qv_w[2] !== 1'b0)
            $display("FAIL rdw_hold2: d2 q=%h v=%b, want 55/0", q_w[2], qv_w[2]);
        else n_pass++;
    endtask

    // clr with a same-cycle write, accesses ignored while busy, then readback.
    task automatic test_clear();
        int bc [3];
        int stray;
        en = 1'b1; we = 1'b1; addr = 6'd7; data = 8'h12; clr = 1'b1;
        tick();
        clr = 1'b0;
        n_chk++;
        if (busy_w[0] !== 1'b1 || busy_w[1] !== 1'b1 || busy_w[2] !== 1'b1 ||
            q_w[0] !== 8'h00 || qv_w[0] !== 1'b1 || q_w[1] !== 8'h12 || qv_w[1] !== 1'b1 || qv_w[2] !== 1'b0)
            $display("FAIL clr_start: busy=%b%b%b d0 %h/%b d1 %h/%b d2 v=%b, want 111 00/1 12/1 v=0",
                     busy_w[0], busy_w[1], busy_w[2], q_w[0], qv_w[0], q_w[1], qv_w[1], qv_w[2]);
        else n_pass++;
        data = 8'h34;
        tick();
        n_chk++;
        if (q_w[2] !== 8'h12 || qv_w[2] !== 1'b1 || qv_w[0] !== 1'b0 || qv_w[1] !== 1'b0)
            $display("FAIL clr_inflight: d2 q=%h v=%b d0 v=%b d1 v=%b, want 12/1 0 0",
                     q_w[2], qv_w[2], qv_w[0], qv_w[1]);
        else n_pass++;
        stray = 0;
        for (int d = 0; d < 3; d++) bc[d] = 2;
        for (int j = 0; j < 62; j++) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                if (busy_w[d] === 1'b1) bc[d]++;
                if (qv_w[d] !== 1'b0) stray++;
            end
        end
        en = 1'b0;
        tick();
        for (int d = 0; d < 3; d++) begin
            n_chk++;
            if (bc[d] != 64 || busy_w[d] !== 1'b0)
                $display("FAIL clr_busy_len d%0d: busy cycles=%0d now=%b, want 64 now=0",
                         d, bc[d], busy_w[d]);
            else n_pass++;
        end
        n_chk++;
        if (stray != 0)
            $display("FAIL clr_ignore_en: q_valid pulses during busy=%0d, want 0", stray);
        else n_pass++;
        en = 1'b1; we = 1'b0; addr = 6'd7;
        tick();
        en = 1'b0;
        n_chk++;
        if (q_w[0] !== 8'h00 || qv_w[0] !== 1'b1 || q_w[1] !== 8'h00 || qv_w[1] !== 1'b1)
            $display("FAIL clr_read7: d0 %h/%b d1 %h/%b, want 00/1 00/1",
                     q_w[0], qv_w[0], q_w[1], qv_w[1]);
        else n_pass++;
        tick();
        n_chk++;
        if (q_w[2] !== 8'hFF || qv_w[2] !== 1'b1)
            $display("FAIL clr_read7_d2: q=%h v=%b, want FF/1", q_w[2], qv_w[2]);
        else n_pass++;
    endtask

    // Reset dropping an in-flight result, and reset in the middle of a clear.
    task automatic test_rst_mid();
        int bc [3];
        en = 1'b1; we = 1'b0; addr = 6'd4;
        tick();
        en = 1'b0;
        n_chk++;
        if (qv_w[0] !== 1'b1 || q_w[0] !== 8'h00)
            $display("FAIL rst_pre_read: d0 q=%h v=%b, want 00/1", q_w[0], qv_w[0]);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            n_chk++;
            if (q_w[d] !== 8'h00 || qv_w[d] !== 1'b0 || busy_w[d] !== 1'b1)
                $display("FAIL rst_drop d%0d: q=%h v=%b busy=%b, want 00/0 busy=1",
                         d, q_w[d], qv_w[d], busy_w[d]);
            else n_pass++;
        end
        for (int i = 0; i < 20; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            n_chk++;
            if (q_w[d] !== 8'h00 || qv_w[d] !== 1'b0)
                $display("FAIL rst_mid_clear_q d%0d: q=%h v=%b, want 00/0", d, q_w[d], qv_w[d]);
            else n_pass++;
            bc[d] = 0;
        end
        for (int i = 0; i < 70; i++) begin
            for (int d = 0; d < 3; d++) if (busy_w[d] === 1'b1) bc[d]++;
            tick();
        end
        for (int d = 0; d < 3; d++) begin
            n_chk++;
            if (bc[d] != 64 || busy_w[d] !== 1'b0)
                $display("FAIL rst_mid_clear_busy d%0d: busy cycles=%0d now=%b, want 64 now=0",
                         d, bc[d], busy_w[d]);
            else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; we = 1'b0; clr = 1'b0; addr = '0; data = '0;
        test_reset();
        test_back_to_back();
        test_rdw();
        test_clear();
        test_rst_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
